spart_bus_driver: RTL

- Synthesizable bus master for the SPART peripheral. It replaces the hand-sequenced bench stimulus with a real FSM.
- After reset it programs the baud divisor from br_cfg, then runs a byte echo loop: it reads received bytes into an internal FIFO and writes them back to the transmit buffer whenever the SPART can accept them.
- It sits between the board switches/reset and the SPART I/O bus (iocs/iorw/ioaddr/databus).

---
 rtl/spart_bus_if.sv | 13 +
 rtl/spart_bus_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_if.sv
// SPART I/O bus handshake: chip select, direction, register address and the
// receive/transmit status pins. The bidirectional data bus is kept as a plain
// inout port on the driver so tristate resolution stays at module boundaries.
interface spart_bus_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_bus_driver.sv
// SPART bus master: programs the baud divisor selected by br_cfg after reset,
// then echoes received bytes through a small FIFO back to the transmit buffer.
// Optional feature macro SPART_DRV_STATUS_POLL_EN: rda/tbr are taken from a
// status-register read (ioaddr=01) instead of the dedicated pins.
module spart_bus_driver #(
    parameter int          DEPTH    = 4,
    parameter int          CS_HOLD  = 2,
    parameter logic [15:0] DIV_CFG0 = 16'h028A,
    parameter logic [15:0] DIV_CFG1 = 16'h0145,
    parameter logic [15:0] DIV_CFG2 = 16'h00A2,
    parameter logic [15:0] DIV_CFG3 = 16'h0050
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 br_cfg,
    spart_bus_if.master                bus,
    inout  wire  [7:0]                 databus,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overrun
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(CS_HOLD - 1);

    localparam logic [2:0] S_LATCH = 3'd0;
    localparam logic [2:0] S_DB_LO = 3'd1;
    localparam logic [2:0] S_DB_HI = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_RD    = 3'd4;
    localparam logic [2:0] S_WR    = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;
    localparam logic [2:0] S_STAT  = 3'd7;

    logic [2:0]    state;
    logic [HW-1:0] hold_cnt;
    logic          gap_to_hi;
    logic          last_rd;
    logic          push_pend;
    logic          drv_en;
    logic [15:0]   div;
    logic [15:0]   div_sel;
    logic [7:0]    dout;
    logic [7:0]    rx_byte;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          acc_end;
    logic          fifo_full;
    logic          fifo_empty;
    logic          rda_s;
    logic          tbr_s;
    logic          arb_ok;
    logic          want_rd;
    logic          want_wr;
    logic          pick_rd;
    logic          pick_wr;
`ifdef SPART_DRV_STATUS_POLL_EN
    logic          poll_vld;
    logic          st_rda;
    logic          st_tbr;
`endif

    function automatic logic [15:0] sel_div(input logic [1:0] cfg);
        case (cfg)
            2'b00:   return DIV_CFG0;
            2'b01:   return DIV_CFG1;
            2'b10:   return DIV_CFG2;
            default: return DIV_CFG3;
        endcase
    endfunction

    assign div_sel    = sel_div(br_cfg);
    assign acc_end    = (hold_cnt == '0);
    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign databus    = drv_en ? dout : 8'hzz;

    // Arbitration between receive and transmit service; ties alternate
    always_comb begin
`ifdef SPART_DRV_STATUS_POLL_EN
        arb_ok = poll_vld;
        rda_s  = st_rda;
        tbr_s  = st_tbr;
`else
        arb_ok = 1'b1;
        rda_s  = bus.rda;
        tbr_s  = bus.tbr;
`endif
        want_rd = arb_ok & rda_s;
        want_wr = arb_ok & tbr_s & ~fifo_empty;
        pick_rd = want_rd & (~want_wr | ~last_rd);
        pick_wr = want_wr & (~want_rd | last_rd);
    end

    // Control FSM, bus strobes and FIFO bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_LATCH;
            hold_cnt   <= '0;
            gap_to_hi  <= 1'b0;
            last_rd    <= 1'b0;
            push_pend  <= 1'b0;
            drv_en     <= 1'b0;
            bus.iocs   <= 1'b0;
            bus.iorw   <= 1'b0;
            bus.ioaddr <= 2'b10;
            busy       <= 1'b1;
            overrun    <= 1'b0;
            fifo_count <= '0;
            wp         <= '0;
            rp         <= '0;
`ifdef SPART_DRV_STATUS_POLL_EN
            poll_vld   <= 1'b0;
`endif
        end else begin
            push_pend <= 1'b0;
            if (push_pend) begin
                if (fifo_full) begin
                    overrun <= 1'b1;
                end else begin
                    wp         <= wp + 1'b1;
                    fifo_count <= fifo_count + 1'b1;
                end
            end
            case (state)
                S_LATCH: begin
                    state      <= S_DB_LO;
                    bus.iocs   <= 1'b1;
                    bus.iorw   <= 1'b0;
                    bus.ioaddr <= 2'b10;
                    drv_en     <= 1'b1;
                    hold_cnt   <= HOLD_LD;
                end
                S_DB_LO, S_DB_HI, S_RD, S_WR, S_STAT: begin
                    if (acc_end) begin
                        bus.iocs  <= 1'b0;
                        drv_en    <= 1'b0;
                        state     <= S_GAP;
                        gap_to_hi <= (state == S_DB_LO);
                        if (state == S_DB_HI) busy <= 1'b0;
                        if (state == S_RD) push_pend <= 1'b1;
                        if (state == S_WR) begin
                            rp         <= rp + 1'b1;
                            fifo_count <= fifo_count - 1'b1;
                        end
`ifdef SPART_DRV_STATUS_POLL_EN
                        if (state == S_STAT) poll_vld <= 1'b1;
`endif
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_to_hi) begin
                        state      <= S_DB_HI;
                        bus.iocs   <= 1'b1;
                        bus.iorw   <= 1'b0;
                        bus.ioaddr <= 2'b11;
                        drv_en     <= 1'b1;
                        hold_cnt   <= HOLD_LD;
                        gap_to_hi  <= 1'b0;
                    end else begin
                        state <= S_RUN;
                    end
                end
                default: begin
`ifdef SPART_DRV_STATUS_POLL_EN
                    poll_vld <= 1'b0;
`endif
                    if (pick_rd) begin
                        state      <= S_RD;
                        bus.iocs   <= 1'b1;
                        bus.iorw   <= 1'b1;
                        bus.ioaddr <= 2'b00;
                        hold_cnt   <= HOLD_LD;
                        last_rd    <= 1'b1;
                    end else if (pick_wr) begin
                        state      <= S_WR;
                        bus.iocs   <= 1'b1;
                        bus.iorw   <= 1'b0;
                        bus.ioaddr <= 2'b00;
                        drv_en     <= 1'b1;
                        hold_cnt   <= HOLD_LD;
                        last_rd    <= 1'b0;
                    end
`ifdef SPART_DRV_STATUS_POLL_EN
                    else if (!poll_vld) begin
                        state      <= S_STAT;
                        bus.iocs   <= 1'b1;
                        bus.iorw   <= 1'b1;
                        bus.ioaddr <= 2'b01;
                        hold_cnt   <= HOLD_LD;
                    end
`endif
                end
            endcase
        end
    end

    // Divisor latch, transmit data staging, receive capture and FIFO storage
    always_ff @(posedge clk) begin
        if (push_pend && !fifo_full) mem[wp] <= rx_byte;
        case (state)
            S_LATCH: begin
                div  <= div_sel;
                dout <= div_sel[7:0];
            end
            S_GAP:   if (gap_to_hi) dout <= div[15:8];
            S_RUN:   if (pick_wr) dout <= mem[rp];
            S_RD:    if (acc_end) rx_byte <= databus;
`ifdef SPART_DRV_STATUS_POLL_EN
            S_STAT: if (acc_end) begin
                st_tbr <= databus[0];
                st_rda <= databus[1];
            end
`endif
            default: ;
        endcase
    end

endmodule
